linebuf_wrctrl: RTL

Write-side controller for the line-multiplier line buffer. Accepts the pixel-qualified N64 video stream (sync flags plus colour word) and turns each active line into a contiguous burst of writes into one page of the two-port line RAM. The page index advances per line and is reset per frame. Each completed line is reported to the read-side scheduler with its page and length.

---
 rtl/linebuf_wrctrl_pkg.sv | 18 +
 rtl/linebuf_wrctrl_sync_edge_det.sv | 25 ++
 rtl/linebuf_wrctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/linebuf_wrctrl_pkg.sv
// rtl/linebuf_wrctrl_pkg.sv - shared video types and width helpers for the line buffer
package linebuf_wrctrl_pkg;

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        LINE_WAIT = 2'd1,
        SKIP      = 2'd2,
        CAPTURE   = 2'd3
    } lb_state_e;

    localparam int unsigned PIX_WIDTH_DEF = 21;

    // Index width for n entries; never below one bit so single-entry cases stay legal.
    function automatic int unsigned lb_idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/linebuf_wrctrl_sync_edge_det.sv
// rtl/linebuf_wrctrl_sync_edge_det.sv - pix_valid-qualified sync edge detector
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    input  logic sync_n_i,
    output logic fall_o,
    output logic rise_o
);

    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b1;
        end else if (valid_i) begin
            sync_q <= sync_n_i;
        end
    end

    // Edges are reported on the sample that carries them, so the FSM can act on that pixel.
    assign fall_o = valid_i & sync_q & ~sync_n_i;
    assign rise_o = valid_i & ~sync_q & sync_n_i;

endmodule

// File: rtl/linebuf_wrctrl.sv
// rtl/linebuf_wrctrl.sv - write-side controller turning video lines into line RAM page bursts
module linebuf_wrctrl
    import linebuf_wrctrl_pkg::*;
#(
    parameter int num_of_pages = 4,
    parameter int pagesize     = 1024,
    parameter int data_width   = PIX_WIDTH_DEF,
    parameter int h_start      = 0,
    localparam int PW = lb_idx_width(num_of_pages),
    localparam int AW = lb_idx_width(pagesize),
    localparam int LW = $clog2(pagesize + 1)
) (
    input  logic                  VCLK,
    input  logic                  nRST,
    input  logic                  pix_valid,
    input  logic                  hsync_n,
    input  logic                  vsync_n,
    input  logic [data_width-1:0] pixdata,
    output logic                  wren,
    output logic [PW-1:0]         wrpage,
    output logic [AW-1:0]         wraddr,
    output logic [data_width-1:0] wrdata,
    output logic                  line_done,
    output logic [PW-1:0]         line_page,
    output logic [LW-1:0]         line_len,
    output logic                  line_ovf,
    output logic                  frame_start
);

    localparam int SW = lb_idx_width(h_start + 1);
    localparam logic [LW-1:0] PAGE_LEN  = LW'(pagesize);
    localparam logic [PW-1:0] LAST_PAGE = PW'(num_of_pages - 1);
    localparam logic [SW-1:0] SKIP_LAST = SW'(h_start - 1);

    logic h_fall, h_rise, v_fall, v_rise;
    logic unused_v_rise;

    lb_state_e             state_q;
    logic [PW-1:0]         page_q;
    logic [LW-1:0]         count_q;
    logic [SW-1:0]         skip_q;
    logic                  ovf_q;
    logic                  wren_q, line_done_q, line_ovf_q, frame_start_q;
    logic [PW-1:0]         wrpage_q, line_page_q;
    logic [AW-1:0]         wraddr_q;
    logic [data_width-1:0] wrdata_q;
    logic [LW-1:0]         line_len_q;

    sync_edge_det u_hsync_det (
        .clk      (VCLK),
        .rst_n    (nRST),
        .valid_i  (pix_valid),
        .sync_n_i (hsync_n),
        .fall_o   (h_fall),
        .rise_o   (h_rise)
    );

    sync_edge_det u_vsync_det (
        .clk      (VCLK),
        .rst_n    (nRST),
        .valid_i  (pix_valid),
        .sync_n_i (vsync_n),
        .fall_o   (v_fall),
        .rise_o   (v_rise)
    );

    assign unused_v_rise = v_rise;

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= SYNC_WAIT;
            page_q        <= '0;
            count_q       <= '0;
            skip_q        <= '0;
            ovf_q         <= 1'b0;
            wren_q        <= 1'b0;
            wrpage_q      <= '0;
            wraddr_q      <= '0;
            wrdata_q      <= '0;
            line_done_q   <= 1'b0;
            line_page_q   <= '0;
            line_len_q    <= '0;
            line_ovf_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            wren_q        <= 1'b0;
            line_done_q   <= 1'b0;
            frame_start_q <= 1'b0;
            if (v_fall) begin
                // A new frame wins over anything hsync is doing on the same sample.
                frame_start_q <= 1'b1;
                page_q        <= '0;
                count_q       <= '0;
                ovf_q         <= 1'b0;
                state_q       <= LINE_WAIT;
            end else if (pix_valid) begin
                case (state_q)
                    SYNC_WAIT: ;
                    LINE_WAIT: begin
                        if (h_rise) begin
                            if (h_start == 0) begin
                                wren_q   <= 1'b1;
                                wrpage_q <= page_q;
                                wraddr_q <= '0;
                                wrdata_q <= pixdata;
                                count_q  <= LW'(1);
                                state_q  <= CAPTURE;
                            end else if (h_start == 1) begin
                                state_q <= CAPTURE;
                            end else begin
                                skip_q  <= SW'(1);
                                state_q <= SKIP;
                            end
                        end
                    end
                    SKIP: begin
                        if (h_fall) begin
                            state_q <= LINE_WAIT;
                        end else if (skip_q == SKIP_LAST) begin
                            state_q <= CAPTURE;
                        end else begin
                            skip_q <= skip_q + SW'(1);
                        end
                    end
                    CAPTURE: begin
                        if (h_fall) begin
                            if (count_q != '0) begin
                                line_done_q <= 1'b1;
                                line_page_q <= page_q;
                                line_len_q  <= count_q;
                                line_ovf_q  <= ovf_q;
                                page_q      <= (page_q == LAST_PAGE) ? '0 : page_q + PW'(1);
                            end
                            count_q <= '0;
                            ovf_q   <= 1'b0;
                            state_q <= LINE_WAIT;
                        end else if (count_q < PAGE_LEN) begin
                            wren_q   <= 1'b1;
                            wrpage_q <= page_q;
                            wraddr_q <= count_q[AW-1:0];
                            wrdata_q <= pixdata;
                            count_q  <= count_q + LW'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                    default: state_q <= SYNC_WAIT;
                endcase
            end
        end
    end

    assign wren        = wren_q;
    assign wrpage      = wrpage_q;
    assign wraddr      = wraddr_q;
    assign wrdata      = wrdata_q;
    assign line_done   = line_done_q;
    assign line_page   = line_page_q;
    assign line_len    = line_len_q;
    assign line_ovf    = line_ovf_q;
    assign frame_start = frame_start_q;

endmodule
